// File: rtl/booth_radix4_multiplier_if.sv
// Handshake and operand bundle for booth_radix4_multiplier.
// master: the sequencer that issues requests; slave: the multiplier.
interface booth_radix4_multiplier_if #(
  parameter int N = 8
);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           done;
  logic           busy;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  product, done, busy
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output product, done, busy
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 (modified) Booth multiplier.
// Retires two multiplier bits per cycle; start/done/busy handshake.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand at accept skips the
// iteration phase and returns product 0 one cycle after accept.
module booth_radix4_multiplier #(
  parameter int N = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  booth_radix4_multiplier_if.slave     bus
);

  // Operands are widened by two bits, then rounded up to an even width so
  // that the multiplier splits into whole radix-4 digits.
  localparam int W    = (((N + 2) % 2) == 0) ? (N + 2) : (N + 3);
  localparam int ITER = W / 2;
  localparam int AW   = 2 * W;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Recode a Booth triplet {b[2i+1], b[2i], b[2i-1]} into {neg, dbl, nz}.
  function automatic logic [2:0] booth_recode(input logic [2:0] trip);
    case (trip)
      3'b000:  booth_recode = 3'b000;  //  0
      3'b001:  booth_recode = 3'b001;  // +1
      3'b010:  booth_recode = 3'b001;  // +1
      3'b011:  booth_recode = 3'b011;  // +2
      3'b100:  booth_recode = 3'b111;  // -2
      3'b101:  booth_recode = 3'b101;  // -1
      3'b110:  booth_recode = 3'b101;  // -1
      3'b111:  booth_recode = 3'b000;  //  0
      default: booth_recode = 3'b000;
    endcase
  endfunction

  state_t          state_r, state_nx_s;
  logic [AW-1:0]   a_sh_r;      // multiplicand, pre-shifted by 2i
  logic [W:0]      b_sh_r;      // {multiplier_ext, 1'b0}, shifted right by 2i
  logic [AW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic [2*N-1:0]  product_r;
  logic            done_r;
  logic            busy_r;

  logic            accept_s;
  logic            last_s;
  logic            skip_s;
  logic [AW-1:0]   a_ext_s;
  logic [W:0]      b_ext_s;
  logic [2:0]      digit_s;
  logic [AW-1:0]   mag_s;
  logic [AW-1:0]   addend_s;
  logic [AW-1:0]   sum_s;

`ifdef BOOTH_ZERO_SKIP_EN
  assign skip_s = (bus.multiplicand == {N{1'b0}}) || (bus.multiplier == {N{1'b0}});
`else
  assign skip_s = 1'b0;
`endif

  // Sign- or zero-extend the incoming operands for latching at accept.
  always_comb begin
    a_ext_s = {AW{1'b0}};
    b_ext_s = {(W + 1){1'b0}};
    if (bus.signed_mode) begin
      a_ext_s = {{(AW - N){bus.multiplicand[N-1]}}, bus.multiplicand};
      b_ext_s = {{(W - N){bus.multiplier[N-1]}}, bus.multiplier, 1'b0};
    end else begin
      a_ext_s = {{(AW - N){1'b0}}, bus.multiplicand};
      b_ext_s = {{(W - N){1'b0}}, bus.multiplier, 1'b0};
    end
  end

  // Booth partial product for the current digit; negation is ~x + carry-in.
  always_comb begin
    digit_s  = booth_recode(b_sh_r[2:0]);
    mag_s    = {AW{1'b0}};
    addend_s = {AW{1'b0}};
    if (digit_s[0]) begin
      if (digit_s[1]) begin
        mag_s = a_sh_r << 1;
      end else begin
        mag_s = a_sh_r;
      end
    end else begin
      mag_s = {AW{1'b0}};
    end
    if (digit_s[2]) begin
      addend_s = ~mag_s;
    end else begin
      addend_s = mag_s;
    end
    sum_s = acc_r + addend_s + {{(AW - 1){1'b0}}, digit_s[2]};
  end

  // Next-state logic: accept from IDLE/DONE, iterate in RUN, pulse in DONE.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          if (skip_s) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_sh_r    <= {AW{1'b0}};
      b_sh_r    <= {(W + 1){1'b0}};
      acc_r     <= {AW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {(2 * N){1'b0}};
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= (state_nx_s == DONE);
      busy_r  <= (state_nx_s == RUN);
      if (accept_s) begin
        a_sh_r <= a_ext_s;
        b_sh_r <= b_ext_s;
        acc_r  <= {AW{1'b0}};
        cnt_r  <= {CW{1'b0}};
        if (skip_s) begin
          product_r <= {(2 * N){1'b0}};
        end
      end else if (state_r == RUN) begin
        a_sh_r <= a_sh_r << 2;
        b_sh_r <= b_sh_r >> 2;
        acc_r  <= sum_s;
        cnt_r  <= cnt_r + CW'(1);
        if (last_s) begin
          product_r <= sum_s[2*N-1:0];
        end
      end
    end
  end

  assign bus.product = product_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;

endmodule

// File: doc/booth_radix4_multiplier.md
# booth_radix4_multiplier

Sequential radix-4 (modified) Booth multiplier, parametrised in operand width, with a runtime signed/unsigned mode and a start/done/busy handshake. It is the next-generation replacement for the radix-2 sequential multiplier in the datapath. It retires two multiplier bits per cycle, roughly halving latency. It drives the same start/done control sequencer as the block it replaces.

## Interface
- N, default 8: operand width in bits; legal range 2..32.
- clk  input  1: rising-edge clock.
- rst  input  1: synchronous, active-high reset.
- start  input  1: request; sampled only when busy=0.
- signed_mode  input  1: 1 = two's-complement operands, 0 = unsigned; latched with the operands.
- multiplicand  input  N: operand A; latched on the accepting edge.
- multiplier  input  N: operand B; latched on the accepting edge.
- product  output  2N: A*B. Registered and held until the next result is written.
- done  output  1: one-cycle pulse; product is valid in the same cycle.
- busy  output  1: high while an operation is in flight.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: one Booth digit per cycle.
  - DONE: done=1 for one cycle.
- Accept: start=1 at an edge while in IDLE or DONE.
  - Latch both operands and signed_mode.
  - Go to RUN with the digit counter at 0.
  - start while in RUN is ignored; the current operation is unaffected.
- Extension:
  - Extend both operands by 2 bits: sign-extend if signed_mode=1, zero-extend if 0.
  - If the result has odd width, extend one more bit to reach an even width W.
  - ITER = W/2. N=8 gives W=10, ITER=5. N=5 gives W=8, ITER=4.
- Each RUN cycle:
  - Recode the triplet {B[2i+1], B[2i], B[2i-1]} (B[-1]=0) to a digit in {-2,-1,0,+1,+2}.
  - Add digit*A, sign-extended to a 2W-bit accumulator, shifted left by 2i.
  - ±2A is a 1-bit left shift; negation is invert plus carry-in.
- On the ITER-th RUN edge:
  - Write product = accumulator[2N-1:0].
  - Assert done and move to DONE.
  - Arithmetic is exact modulo 2^(2N); no overflow is possible.
- DONE → IDLE on the next edge, unless start re-arms directly to RUN (back-to-back).
- Reset values: state IDLE; product=0, done=0, busy=0; all internal registers 0.
- Reset mid-operation: the operation is discarded, no done is produced, and product returns to 0.

## Timing
- Accepting edge t0. busy=1 in the cycles after edges t0 through t0+ITER-1.
- done=1 and the new product are visible only in the cycle after edge t0+ITER; busy=0 in that cycle.
- Latency: ITER cycles from accept to done. Issue interval: ITER+1 cycles (back-to-back start during DONE).
- product changes only at a result-write edge or at reset.
- Operand inputs may change freely after t0.
- If rst and start are both high at the same edge, rst wins.

## Configuration
- BOOTH_ZERO_SKIP_EN defined:
  - At accept, if the latched multiplicand or multiplier is 0, skip RUN.
  - product=0 is written and done=1 at edge t0 itself (1-cycle latency); busy stays 0.
- BOOTH_ZERO_SKIP_EN undefined:
  - Zero operands take the full ITER cycles and produce product=0.
- Non-zero operands behave identically with or without the macro.

## Test plan
- N=8, signed: -3 × -4 → product=12; done exactly 5 cycles after accept; busy high for 5 cycles.
- N=8, signed: -128 × -128 → 16384. Unsigned: 255 × 255 → 65025. Signed 127 × -128 → -16256 (0xC080).
- N=5, signed: -16 × -16 → 256; 9 × -1 → -9 (0x3F7); ITER=4.
- Pulse start again mid-RUN with different operands → ignored; first result is unchanged. Back-to-back start in the DONE cycle → second result ITER cycles later.
- Assert rst during the 3rd RUN cycle → next cycle product=0, done=0, busy=0; no done pulse follows. A new start then works normally.
- N=8, 7 × 0 → 0:
  - With BOOTH_ZERO_SKIP_EN, done arrives in the cycle after accept.
  - Without it, done arrives after 5 cycles.
